// File: rtl/axi4_sram_pkg.sv
// Shared types and constants for the SRAM-subsystem AXI4 master interface:
// FSM state encoding, burst/response codes and the beat-size helper.
package axi4_sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } mstif_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AxSIZE encoding for a full-width beat: log2 of the bus width in bytes.
    function automatic logic [2:0] beat_size_log2(input int unsigned dwidth);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd8 << i) == dwidth) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/axi4_sram_mstif.sv
// AXI4 master: turns single local commands into INCR write/read bursts, one outstanding.
// Build option AXI4_MSTIF_4K_CHECK_EN rejects commands whose burst crosses a 4 KB boundary.
module axi4_sram_mstif
    import axi4_sram_pkg::*;
#(
    parameter int AXI4_DWIDTH  = 64,
    parameter int AXI4_AWIDTH  = 32,
    parameter int AXI4_IDWIDTH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI4_AWIDTH-1:0]    cmd_addr,
    input  logic [7:0]                cmd_len,
    input  logic [AXI4_IDWIDTH-1:0]   cmd_id,

    input  logic                      wdat_valid,
    output logic                      wdat_ready,
    input  logic [AXI4_DWIDTH-1:0]    wdat_data,
    input  logic [AXI4_DWIDTH/8-1:0]  wdat_strb,

    output logic                      rdat_valid,
    input  logic                      rdat_ready,
    output logic [AXI4_DWIDTH-1:0]    rdat_data,
    output logic                      rdat_last,

    output logic                      done,
    output logic [1:0]                done_resp,

    output logic [AXI4_IDWIDTH-1:0]   AWID,
    output logic [AXI4_AWIDTH-1:0]    AWADDR,
    output logic [7:0]                AWLEN,
    output logic [2:0]                AWSIZE,
    output logic [1:0]                AWBURST,
    output logic                      AWVALID_M,
    input  logic                      AWREADY_M,

    output logic [AXI4_DWIDTH-1:0]    WDATA,
    output logic [AXI4_DWIDTH/8-1:0]  WSTRB,
    output logic                      WLAST,
    output logic                      WVALID_M,
    input  logic                      WREADY_M,

    input  logic [AXI4_IDWIDTH-1:0]   BID,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID_M,
    output logic                      BREADY_M,

    output logic [AXI4_IDWIDTH-1:0]   ARID,
    output logic [AXI4_AWIDTH-1:0]    ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARVALID_M,
    input  logic                      ARREADY_M,

    input  logic [AXI4_IDWIDTH-1:0]   RID,
    input  logic [AXI4_DWIDTH-1:0]    RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID_M,
    output logic                      RREADY_M
);

    localparam logic [2:0] SIZE = beat_size_log2(AXI4_DWIDTH);

    mstif_state_e              state_q, state_d;
    logic [AXI4_AWIDTH-1:0]    addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [AXI4_IDWIDTH-1:0]   id_q, id_d;
    logic [2:0]                size_q, size_d;
    logic [1:0]                burst_q, burst_d;
    logic                      awvalid_q, awvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [1:0]                resp_q, resp_d;
    logic                      err_q, err_d;

    logic in_w, in_r, w_hs, r_hs, last_beat, reject;

`ifdef AXI4_MSTIF_4K_CHECK_EN
    // Byte offset in the page plus burst length; wide enough for 256 beats at any bus width.
    logic [19:0] span;
    assign span   = {8'd0, cmd_addr[11:0]} + (({12'd0, cmd_len} + 20'd1) << SIZE);
    assign reject = (span > 20'd4096);
`else
    assign reject = 1'b0;
`endif

    assign in_w      = (state_q == WR_DATA);
    assign in_r      = (state_q == RD_DATA);
    assign last_beat = (cnt_q == len_q);
    assign w_hs      = in_w && wdat_valid && WREADY_M;
    assign r_hs      = in_r && RVALID_M && rdat_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        id_d      = id_q;
        size_d    = size_q;
        burst_d   = burst_q;
        awvalid_d = awvalid_q;
        arvalid_d = arvalid_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    id_d    = cmd_id;
                    size_d  = SIZE;
                    burst_d = BURST_INCR;
                    cnt_d   = 8'd0;
                    resp_d  = RESP_OKAY;
                    err_d   = 1'b0;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (cmd_write) begin
                        awvalid_d = 1'b1;
                        state_d   = WR_ADDR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (AWREADY_M) begin
                    awvalid_d = 1'b0;
                    state_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_hs) begin
                    if (last_beat) begin
                        cnt_d   = 8'd0;
                        state_d = WR_RESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            WR_RESP: begin
                if (BVALID_M) begin
                    resp_d  = BRESP;
                    if (BID != id_q) err_d = 1'b1;
                    state_d = DONE;
                end
            end
            RD_ADDR: begin
                if (ARREADY_M) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    if (RRESP > resp_q) resp_d = RRESP;
                    // RLAST must coincide with the expected final beat; either way RLAST ends the burst.
                    if ((RID != id_q) || (RLAST != last_beat)) err_d = 1'b1;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (RLAST) begin
                        cnt_d   = 8'd0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            cnt_q     <= '0;
            resp_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            id_q      <= id_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !ARESET;

    assign AWID      = id_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWBURST   = burst_q;
    assign AWVALID_M = awvalid_q;

    assign ARID      = id_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARBURST   = burst_q;
    assign ARVALID_M = arvalid_q;

    // Data streams are pure pass-through while their burst phase is active.
    assign WVALID_M   = in_w && wdat_valid;
    assign wdat_ready = in_w && WREADY_M;
    assign WDATA      = in_w ? wdat_data : '0;
    assign WSTRB      = in_w ? wdat_strb : '0;
    assign WLAST      = in_w && last_beat;

    assign BREADY_M   = (state_q == WR_RESP);

    assign rdat_valid = in_r && RVALID_M;
    assign RREADY_M   = in_r && rdat_ready;
    assign rdat_data  = in_r ? RDATA : '0;
    assign rdat_last  = in_r && RLAST;

    assign done       = (state_q == DONE);
    assign done_resp  = err_q ? RESP_SLVERR : resp_q;

endmodule
